// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with shadow loading,
// per-digit decimal points, leading-zero suppression, blinking and dead time.
module fnd_scan_ctrl #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int DIGITS   = 4,
    parameter int BLINK_HZ = 2,
    parameter int DEAD     = 2,
    parameter int HEX_EN   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     fnd_com,
    output logic [7:0]            fnd_data,
    output logic                  frame_start
);

    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int HB   = CLK_HZ / (2 * BLINK_HZ);
    localparam int DIVW = $clog2(DIV);
    localparam int HBW  = (HB > 1) ? $clog2(HB) : 1;
    localparam int IDXW = $clog2(DIGITS);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);
    localparam logic [DIVW-1:0] DEAD_C   = DIVW'(DEAD);
    localparam logic [HBW-1:0]  HB_LAST  = HBW'(HB - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

    // Lower seven segment bits {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] seg_of(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = (HEX_EN != 0) ? 7'h08 : 7'h7F;
            4'hB: s = (HEX_EN != 0) ? 7'h03 : 7'h7F;
            4'hC: s = (HEX_EN != 0) ? 7'h46 : 7'h7F;
            4'hD: s = (HEX_EN != 0) ? 7'h21 : 7'h7F;
            4'hE: s = (HEX_EN != 0) ? 7'h06 : 7'h7F;
            default: s = (HEX_EN != 0) ? 7'h0E : 7'h7F;
        endcase
        return s;
    endfunction

    logic [DIVW-1:0]     div_q, div_d;
    logic [IDXW-1:0]     idx_q, idx_d, idx_nx;
    logic [HBW-1:0]      hb_q, hb_d;
    logic                phase_q, phase_d;
    logic [4*DIGITS-1:0] code_q, code_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   blink_q, blink_d;
    logic                lz_q, lz_d;
    logic [7:0]          data_q, data_d;
    logic                blank_q, blank_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                all_zero;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          code_nx;

    // Slot entry uses next-cycle shadow values so a load coinciding with a tick takes effect at once.
    always_comb begin
        tick    = (div_q == DIV_LAST);
        code_d  = load ? bcd   : code_q;
        dp_d    = load ? dp    : dp_q;
        blink_d = load ? blink : blink_q;
        lz_d    = load ? lz_en : lz_q;

        div_d  = tick ? '0 : div_q + 1'b1;
        idx_nx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        idx_d  = tick ? idx_nx : idx_q;

        hb_d    = (hb_q == HB_LAST) ? '0 : hb_q + 1'b1;
        phase_d = (hb_q == HB_LAST) ? ~phase_q : phase_q;

        supp     = '0;
        all_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (code_d[4*k +: 4] == 4'h0);
            supp[k]  = lz_d & all_zero;
        end

        code_nx = code_d[{idx_nx, 2'b00} +: 4];
        data_d  = data_q;
        blank_d = blank_q;
        frame_d = 1'b0;
        if (tick) begin
            data_d  = supp[idx_nx] ? 8'hFF : {~dp_d[idx_nx], seg_of(code_nx)};
            blank_d = blink_d[idx_nx] & phase_q;
            frame_d = (idx_nx == '0);
        end
    end

    // Reset leaves the first slot (digit 0, zero shadows -> "0" pattern) already loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            idx_q   <= '0;
            hb_q    <= '0;
            phase_q <= 1'b0;
            code_q  <= '0;
            dp_q    <= '0;
            blink_q <= '0;
            lz_q    <= 1'b0;
            data_q  <= 8'hC0;
            blank_q <= 1'b0;
            frame_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            hb_q    <= hb_d;
            phase_q <= phase_d;
            code_q  <= code_d;
            dp_q    <= dp_d;
            blink_q <= blink_d;
            lz_q    <= lz_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            frame_q <= frame_d;
        end
    end

    // While rst is held the pins stay dark; the first cycle after release is the first slot.
    always_comb begin
        fnd_com = '1;
        if (!rst && !blank_q && !(div_q < DEAD_C))
            fnd_com = ~(DIGITS'(1) << idx_q);
        fnd_data    = rst ? 8'hFF : data_q;
        frame_start = frame_q & ~rst;
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl: DIV=10, DEAD=2, DIGITS=4, HB=50, with a
// decimal-only instance and a hex-enabled instance sharing the same inputs.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] bcd = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        lz_en = 1'b0;

    logic [3:0]  fnd_com, hex_com;
    logic [7:0]  fnd_data, hex_data;
    logic        frame_start, hex_frame;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fnd_scan_ctrl #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .BLINK_HZ(10), .DEAD(2), .HEX_EN(0)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .dp(dp), .blink(blink),
        .lz_en(lz_en), .fnd_com(fnd_com), .fnd_data(fnd_data), .frame_start(frame_start)
    );

    fnd_scan_ctrl #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .BLINK_HZ(10), .DEAD(2), .HEX_EN(1)
    ) dut_hex (
        .clk(clk), .rst(rst), .load(load), .bcd(bcd), .dp(dp), .blink(blink),
        .lz_en(lz_en), .fnd_com(hex_com), .fnd_data(hex_data), .frame_start(hex_frame)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        load = 1'b0;
        cyc++;
    endtask

    // Advance to the middle of cycle n after release (cycle 1 = first cycle with rst low).
    task automatic waitCycle(input int n);
        while (cyc < n) nextCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] b, input logic [3:0] d,
                                 input logic [3:0] bl, input logic lz);
        rst  = 1'b1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        load  = 1'b1;
        bcd   = b;
        dp    = d;
        blink = bl;
        lz_en = lz;
        cyc   = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_com",   16'(fnd_com),     16'hF);
        checkOutput("rst_data",  16'(fnd_data),    16'hFF);
        checkOutput("rst_frame", 16'(frame_start), 16'h0);

        // Plain scan of 1234
        applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
        waitCycle(1);
        checkOutput("a_r1_frame", 16'(frame_start), 16'h1);
        checkOutput("a_r1_com",   16'(fnd_com),     16'hF);
        checkOutput("a_r1_data",  16'(fnd_data),    16'hC0);
        waitCycle(2);
        checkOutput("a_r2_com",   16'(fnd_com),     16'hF);
        checkOutput("a_r2_frame", 16'(frame_start), 16'h0);
        waitCycle(3);
        checkOutput("a_r3_com",   16'(fnd_com),     16'hE);
        checkOutput("a_r3_data",  16'(fnd_data),    16'hC0);
        waitCycle(11);
        checkOutput("a_d1_data",  16'(fnd_data),    16'hB0);
        checkOutput("a_d1_dead",  16'(fnd_com),     16'hF);
        waitCycle(13);
        checkOutput("a_d1_com",   16'(fnd_com),     16'hD);
        waitCycle(23);
        checkOutput("a_d2_com",   16'(fnd_com),     16'hB);
        checkOutput("a_d2_data",  16'(fnd_data),    16'hA4);
        waitCycle(33);
        checkOutput("a_d3_com",   16'(fnd_com),     16'h7);
        checkOutput("a_d3_data",  16'(fnd_data),    16'hF9);
        waitCycle(40);
        checkOutput("a_r40_frame", 16'(frame_start), 16'h0);
        checkOutput("a_r40_com",   16'(fnd_com),     16'h7);
        waitCycle(41);
        checkOutput("a_r41_frame", 16'(frame_start), 16'h1);
        checkOutput("a_d0_data",   16'(fnd_data),    16'h99);
        checkOutput("a_r41_com",   16'(fnd_com),     16'hF);
        waitCycle(43);
        checkOutput("a_d0_com",    16'(fnd_com),     16'hE);

        // Leading-zero suppression with all decimal points requested
        applyStimulus(16'h0070, 4'b1111, 4'b0000, 1'b1);
        waitCycle(11);
        checkOutput("b_d1_data", 16'(fnd_data), 16'h78);
        waitCycle(21);
        checkOutput("b_d2_data", 16'(fnd_data), 16'hFF);
        waitCycle(23);
        checkOutput("b_d2_com",  16'(fnd_com),  16'hB);
        waitCycle(31);
        checkOutput("b_d3_data", 16'(fnd_data), 16'hFF);
        waitCycle(41);
        checkOutput("b_d0_data", 16'(fnd_data), 16'h40);
        waitCycle(45);
        load = 1'b1;
        bcd  = 16'h0000;
        waitCycle(51);
        checkOutput("b_zero_d1", 16'(fnd_data), 16'hFF);
        waitCycle(71);
        checkOutput("b_zero_d3", 16'(fnd_data), 16'hFF);
        waitCycle(81);
        checkOutput("b_zero_d0", 16'(fnd_data), 16'h40);

        // Single decimal point on digit 2
        applyStimulus(16'h1259, 4'b0100, 4'b0000, 1'b0);
        waitCycle(11);
        checkOutput("c_d1_data", 16'(fnd_data), 16'h92);
        waitCycle(21);
        checkOutput("c_d2_data", 16'(fnd_data), 16'h24);
        waitCycle(31);
        checkOutput("c_d3_data", 16'(fnd_data), 16'hF9);
        waitCycle(41);
        checkOutput("c_d0_data", 16'(fnd_data), 16'h90);

        // Hex codes: blank on the decimal instance, letters on the hex instance
        applyStimulus(16'hABCF, 4'b0000, 4'b0000, 1'b0);
        waitCycle(11);
        checkOutput("d_dec_d1", 16'(fnd_data), 16'hFF);
        checkOutput("d_hex_d1", 16'(hex_data), 16'hC6);
        waitCycle(21);
        checkOutput("d_hex_d2", 16'(hex_data), 16'h83);
        waitCycle(31);
        checkOutput("d_hex_d3", 16'(hex_data), 16'h88);
        checkOutput("d_dec_d3", 16'(fnd_data), 16'hFF);
        waitCycle(41);
        checkOutput("d_hex_d0", 16'(hex_data), 16'h8E);
        checkOutput("d_dec_d0", 16'(fnd_data), 16'hFF);

        // Blink on digit 0: phase is 1 during cycles 51..100
        applyStimulus(16'h1234, 4'b0000, 4'b0001, 1'b0);
        waitCycle(43);
        checkOutput("e_d0_phase0", 16'(fnd_com), 16'hE);
        waitCycle(53);
        checkOutput("e_d1_phase1", 16'(fnd_com), 16'hD);
        waitCycle(83);
        checkOutput("e_d0_blank_a", 16'(fnd_com), 16'hF);
        waitCycle(85);
        checkOutput("e_d0_data",    16'(fnd_data), 16'h99);
        waitCycle(90);
        checkOutput("e_d0_blank_b", 16'(fnd_com), 16'hF);
        waitCycle(93);
        checkOutput("e_d1_after",   16'(fnd_com), 16'hD);
        waitCycle(123);
        checkOutput("e_d0_visible", 16'(fnd_com), 16'hE);

        // Mid-slot load, then mid-slot reset with a load that must be ignored
        applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
        waitCycle(11);
        checkOutput("f_d1_old", 16'(fnd_data), 16'hF9);
        waitCycle(15);
        load = 1'b1;
        bcd  = 16'h2222;
        waitCycle(18);
        checkOutput("f_hold_a", 16'(fnd_data), 16'hF9);
        waitCycle(20);
        checkOutput("f_hold_b", 16'(fnd_data), 16'hF9);
        waitCycle(21);
        checkOutput("f_d2_new", 16'(fnd_data), 16'hA4);
        waitCycle(25);
        rst  = 1'b1;
        load = 1'b1;
        bcd  = 16'h5555;
        waitCycle(26);
        checkOutput("f_rst_com",   16'(fnd_com),     16'hF);
        checkOutput("f_rst_data",  16'(fnd_data),    16'hFF);
        checkOutput("f_rst_frame", 16'(frame_start), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
        waitCycle(1);
        checkOutput("f_rel_frame", 16'(frame_start), 16'h1);
        checkOutput("f_rel_data",  16'(fnd_data),    16'hC0);
        waitCycle(3);
        checkOutput("f_rel_com",   16'(fnd_com),     16'hE);
        waitCycle(11);
        checkOutput("f_ignored",   16'(fnd_data),    16'hC0);
        waitCycle(13);
        checkOutput("f_rel_d1com", 16'(fnd_com),     16'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
